// File: rtl/motor_cmd_ctrl_pkg.sv
// Shared types and helpers for the motor command sequencer.
package motor_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'b00,
    FWD   = 2'b01,
    REV   = 2'b10,
    BRAKE = 2'b11
  } motor_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DEAD = 2'b10
  } ctrl_state_t;

  localparam logic [1:0] FRAME_HDR = 2'b10;

  // Only a direct forward<->reverse swap needs a dead-time stop.
  function automatic logic is_reversal(input motor_cmd_t cur, input motor_cmd_t nxt);
    return ((cur == FWD) && (nxt == REV)) || ((cur == REV) && (nxt == FWD));
  endfunction

endpackage

// File: rtl/motor_cmd_ctrl_if.sv
// Byte-receive and motor-command bundle between UART, sequencer and motor drivers.
interface motor_cmd_ctrl_if;
  import motor_pkg::*;

  logic [7:0] rx_data;
  logic       rx_valid;
  motor_cmd_t lcmd;
  motor_cmd_t rcmd;
  logic       busy;
  logic       bad_frame;
  logic       timeout;

  modport master (
    output rx_data, rx_valid,
    input  lcmd, rcmd, busy, bad_frame, timeout
  );

  modport slave (
    input  rx_data, rx_valid,
    output lcmd, rcmd, busy, bad_frame, timeout
  );

endinterface

// File: rtl/motor_cmd_ctrl_frame_check.sv
// Combinational frame validation and command decode for one received byte.
module cmd_frame_check
  import motor_pkg::*;
(
  input  logic [7:0] rx_data_i,
  output logic       frame_ok_o,
  output motor_cmd_t lcmd_o,
  output motor_cmd_t rcmd_o
);

  // Even parity over the whole byte means the XOR of all bits is zero.
  assign frame_ok_o = (rx_data_i[7:6] == FRAME_HDR) && !rx_data_i[1] && !(^rx_data_i);
  assign lcmd_o     = motor_cmd_t'(rx_data_i[5:4]);
  assign rcmd_o     = motor_cmd_t'(rx_data_i[3:2]);

endmodule

// File: rtl/motor_cmd_ctrl.sv
// Motor command sequencer: frame check, dead-time on reversal, optional watchdog.
// Define MOTOR_CTRL_WDT_EN to build the watchdog forced-stop logic.
module motor_cmd_ctrl
  import motor_pkg::*;
#(
  parameter int DEAD_CYCLES = 16,
  parameter int WDT_CYCLES  = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  motor_cmd_ctrl_if.slave  bus
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);

  ctrl_state_t   state_q;
  motor_cmd_t    lcmd_q, rcmd_q;
  motor_cmd_t    pend_l_q, pend_r_q;
  logic [DW-1:0] dead_q;
  logic          busy_q, bad_q, tmo_q;

  logic          frame_ok;
  motor_cmd_t    f_l, f_r;
  logic          good, bad, rev, wdt_fire;

  cmd_frame_check u_chk (
    .rx_data_i  (bus.rx_data),
    .frame_ok_o (frame_ok),
    .lcmd_o     (f_l),
    .rcmd_o     (f_r)
  );

  assign good = bus.rx_valid && frame_ok;
  assign bad  = bus.rx_valid && !frame_ok;
  assign rev  = is_reversal(lcmd_q, f_l) || is_reversal(rcmd_q, f_r);

`ifdef MOTOR_CTRL_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);
  localparam logic [WW-1:0] WDT_MAX  = WW'(WDT_CYCLES);

  logic [WW-1:0] wdt_q, wdt_d;

  function automatic logic [WW-1:0] wdt_inc(input logic [WW-1:0] v);
    return (v == WDT_MAX) ? v : v + 1'b1;
  endfunction

  // A good frame on the expiry cycle suppresses the fire.
  assign wdt_fire = (state_q != IDLE) && !good && (wdt_q == WDT_LAST);

  always_comb begin
    wdt_d = wdt_q;
    if (good || (state_q == IDLE) || wdt_fire) wdt_d = '0;
    else                                      wdt_d = wdt_inc(wdt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) wdt_q <= '0;
    else       wdt_q <= wdt_d;
  end
`else
  // Without the watchdog the forced stop can never happen.
  assign wdt_fire = 1'b0 && (WDT_CYCLES >= 2);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      lcmd_q   <= STOP;
      rcmd_q   <= STOP;
      pend_l_q <= STOP;
      pend_r_q <= STOP;
      dead_q   <= '0;
      busy_q   <= 1'b0;
      bad_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      bad_q <= bad;
      tmo_q <= wdt_fire;
      if (wdt_fire) begin
        state_q  <= IDLE;
        lcmd_q   <= STOP;
        rcmd_q   <= STOP;
        pend_l_q <= STOP;
        pend_r_q <= STOP;
        dead_q   <= '0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE, RUN: begin
            if (good) begin
              if (rev) begin
                state_q  <= DEAD;
                lcmd_q   <= STOP;
                rcmd_q   <= STOP;
                pend_l_q <= f_l;
                pend_r_q <= f_r;
                dead_q   <= DEAD_LOAD;
                busy_q   <= 1'b1;
              end else begin
                state_q <= RUN;
                lcmd_q  <= f_l;
                rcmd_q  <= f_r;
              end
            end
          end
          DEAD: begin
            // A frame arriving on the last dead cycle is the one applied.
            if (dead_q == '0) begin
              state_q <= RUN;
              busy_q  <= 1'b0;
              lcmd_q  <= good ? f_l : pend_l_q;
              rcmd_q  <= good ? f_r : pend_r_q;
            end else begin
              dead_q <= dead_q - 1'b1;
            end
            if (good) begin
              pend_l_q <= f_l;
              pend_r_q <= f_r;
            end
          end
          default: begin
            state_q <= IDLE;
            lcmd_q  <= STOP;
            rcmd_q  <= STOP;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.lcmd      = lcmd_q;
  assign bus.rcmd      = rcmd_q;
  assign bus.busy      = busy_q;
  assign bus.bad_frame = bad_q;
  assign bus.timeout   = tmo_q;

endmodule

// File: tb/tb_motor_cmd_ctrl.sv
// Directed plus randomized bench for motor_cmd_ctrl against a cycle-level behavioural model.
module tb_motor_cmd_ctrl;

  localparam int DEAD = 4;
  localparam int WDT  = 64;
`ifdef MOTOR_CTRL_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  motor_cmd_ctrl_if bus ();

  motor_cmd_ctrl #(.DEAD_CYCLES(DEAD), .WDT_CYCLES(WDT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state
  int m_l, m_r, p_l, p_r, dead_left, quiet;
  bit active;
  bit e_busy, e_bad, e_tmo;

  function automatic bit rev_pair(int a, int b);
    return (a == 1 && b == 2) || (a == 2 && b == 1);
  endfunction

  function automatic logic [7:0] make_frame(int l, int r);
    logic [7:0] b;
    b = {2'b10, 2'(l), 2'(r), 2'b00};
    b[0] = ^b;
    return b;
  endfunction

  task automatic model_reset();
    m_l = 0; m_r = 0; p_l = 0; p_r = 0;
    dead_left = 0; quiet = 0; active = 0;
    e_busy = 0; e_bad = 0; e_tmo = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    bit ok, good;
    int fl, fr;
    ok   = (d[7:6] == 2'b10) && (d[1] == 1'b0) && ($countones(d) % 2 == 0);
    good = v && ok;
    fl   = int'(d[5:4]);
    fr   = int'(d[3:2]);
    e_bad = v && !ok;
    e_tmo = 0;
    if (active && !good) begin
      quiet++;
      if (WDT_ON && quiet >= WDT) begin
        active = 0; m_l = 0; m_r = 0; p_l = 0; p_r = 0;
        dead_left = 0; quiet = 0; e_tmo = 1; e_busy = 0;
        return;
      end
    end
    if (good) quiet = 0;
    if (dead_left > 0) begin
      if (good) begin p_l = fl; p_r = fr; end
      dead_left--;
      if (dead_left == 0) begin m_l = p_l; m_r = p_r; end
    end else if (good) begin
      active = 1;
      if (rev_pair(m_l, fl) || rev_pair(m_r, fr)) begin
        m_l = 0; m_r = 0; p_l = fl; p_r = fr; dead_left = DEAD;
      end else begin
        m_l = fl; m_r = fr;
      end
    end
    e_busy = (dead_left > 0);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".lcmd"},    8'(bus.lcmd),      8'(m_l));
    chk({tag, ".rcmd"},    8'(bus.rcmd),      8'(m_r));
    chk({tag, ".busy"},    8'(bus.busy),      8'(e_busy));
    chk({tag, ".bad"},     8'(bus.bad_frame), 8'(e_bad));
    chk({tag, ".timeout"}, 8'(bus.timeout),   8'(e_tmo));
  endtask

  task automatic cycle(input string tag, input logic v, input logic [7:0] d);
    bus.rx_valid = v;
    bus.rx_data  = d;
    @(posedge clk); #1;
    model_step(v, d);
    bus.rx_valid = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 8'h00);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    model_reset();

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      model_reset();
      check_all("reset");
    end
    reset = 1'b0;
    idle("post_reset", 2);

    // Forward on both sides, then a reversal with dead time
    cycle("fwd", 1'b1, 8'b10010101);
    chk("fwd_lcmd_const", 8'(bus.lcmd), 8'h01);
    idle("run", 2);
    cycle("rev_start", 1'b1, 8'b10101001);
    idle("dead", DEAD - 1);
    chk("dead_busy_last", 8'(bus.busy), 8'h01);
    idle("dead_end", 1);
    chk("rev_applied_l", 8'(bus.lcmd), 8'h02);
    chk("rev_applied_r", 8'(bus.rcmd), 8'h02);
    chk("rev_busy_low", 8'(bus.busy), 8'h00);

    // Rejected bytes leave outputs alone
    cycle("bad_parity", 1'b1, 8'b10010100);
    chk("bad_parity_pulse", 8'(bus.bad_frame), 8'h01);
    cycle("bad_header", 1'b1, 8'b00010101);
    chk("bad_header_pulse", 8'(bus.bad_frame), 8'h01);
    idle("after_bad", 1);

    // Back to 01/01 (itself a reversal) and let the watchdog run out
    cycle("to_fwd", 1'b1, 8'b10010101);
    idle("to_fwd_dead", DEAD + 1);
    cycle("refresh", 1'b1, 8'b10010101);
    idle("wdt_wait", WDT + 4);

    // Reset in the middle of dead time
    cycle("pre_fwd", 1'b1, 8'b10010101);
    idle("pre_fwd_settle", DEAD + 1);
    cycle("rev_again", 1'b1, 8'b10101001);
    idle("dead_partial", 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_all("reset_in_dead");
    idle("after_reset_dead", DEAD + 3);

    // Randomized traffic, with occasional long silences to reach the watchdog
    for (int it = 0; it < 500; it++) begin
      logic       v;
      logic [7:0] d;
      v = ($urandom_range(0, 9) >= 5);
      if ($urandom_range(0, 2) != 0) d = make_frame($urandom_range(0, 3), $urandom_range(0, 3));
      else                           d = 8'($urandom);
      cycle("rand", v, d);
      if (it % 125 == 124) idle("rand_gap", WDT + 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
